// File: rtl/decode_dispatch.sv
// decode_dispatch: RV32I decode-and-dispatch stage with a one-entry output register.
// Decodes one instruction per cycle and resolves its operands from the regfile, ROB or CDB.
// While an entry is held, it snoops the CDB to clear stale tags.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds out_illegal. It flags unknown or all-zero
// encodings, which still dispatch as NOP.
module decode_dispatch #(
  parameter int DATA_W    = 32,
  parameter int ROB_TAG_W = 4,
  parameter int CDB_PORTS = 2,
  parameter int OP_W      = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_inst,
  input  logic [DATA_W-1:0]             in_pc,
  output logic [4:0]                    rs1,
  output logic [4:0]                    rs2,
  input  logic                          in_busy1,
  input  logic                          in_busy2,
  input  logic [ROB_TAG_W-1:0]          in_tag1,
  input  logic [ROB_TAG_W-1:0]          in_tag2,
  input  logic [DATA_W-1:0]             in_operand1,
  input  logic [DATA_W-1:0]             in_operand2,
  output logic [ROB_TAG_W-1:0]          query_tag1,
  output logic [ROB_TAG_W-1:0]          query_tag2,
  input  logic                          in_tag1_ready,
  input  logic                          in_tag2_ready,
  input  logic [DATA_W-1:0]             ready_value1,
  input  logic [DATA_W-1:0]             ready_value2,
  input  logic                          rob_full,
  input  logic [ROB_TAG_W-1:0]          rob_alloc_tag,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_TAG_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_value,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OP_W-1:0]               out_op,
  output logic [DATA_W-1:0]             out_imm,
  output logic [4:0]                    out_rd,
  output logic [DATA_W-1:0]             out_operand1,
  output logic [DATA_W-1:0]             out_operand2,
  output logic [ROB_TAG_W-1:0]          out_tag1,
  output logic [ROB_TAG_W-1:0]          out_tag2,
  output logic [ROB_TAG_W-1:0]          out_rob_tag,
  output logic [DATA_W-1:0]             out_pc
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                          out_illegal
`endif
);

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0),  OP_LUI = OP_W'(1),  OP_AUIPC = OP_W'(2),
    OP_JAL = OP_W'(3),  OP_JALR = OP_W'(4),  OP_BEQ = OP_W'(5),  OP_BNE = OP_W'(6),
    OP_BLT = OP_W'(7),  OP_BGE = OP_W'(8),   OP_BLTU = OP_W'(9), OP_BGEU = OP_W'(10),
    OP_LB = OP_W'(11),  OP_LH = OP_W'(12),   OP_LW = OP_W'(13),  OP_LBU = OP_W'(14),
    OP_LHU = OP_W'(15), OP_SB = OP_W'(16),   OP_SH = OP_W'(17),  OP_SW = OP_W'(18),
    OP_ADDI = OP_W'(19), OP_SLTI = OP_W'(20), OP_SLTIU = OP_W'(21), OP_XORI = OP_W'(22),
    OP_ORI = OP_W'(23), OP_ANDI = OP_W'(24), OP_SLLI = OP_W'(25), OP_SRLI = OP_W'(26),
    OP_SRAI = OP_W'(27), OP_ADD = OP_W'(28),  OP_SUB = OP_W'(29),  OP_SLL = OP_W'(30),
    OP_SLT = OP_W'(31), OP_SLTU = OP_W'(32), OP_XOR = OP_W'(33),  OP_SRL = OP_W'(34),
    OP_SRA = OP_W'(35), OP_OR = OP_W'(36),   OP_AND = OP_W'(37);

  typedef enum logic { S_EMPTY = 1'b0, S_FULL = 1'b1 } state_t;
  typedef struct packed { logic hit; logic [DATA_W-1:0] val; } cdb_hit_t;
  typedef struct packed { logic [DATA_W-1:0] val; logic [ROB_TAG_W-1:0] tag; } opnd_t;

  state_t                state_q, state_d;
  logic                  accept;
  logic [OP_W-1:0]       dec_op, op_q, op_d;
  logic signed [DATA_W-1:0] dec_imm, imm_q, imm_d;
  logic [4:0]            dec_rd, dec_rs1, dec_rs2, rd_q, rd_d;
  logic                  dec_illegal, illegal_q, illegal_d;
  logic [DATA_W-1:0]     opnd1_q, opnd1_d, opnd2_q, opnd2_d, pc_q, pc_d;
  logic [ROB_TAG_W-1:0]  tag1_q, tag1_d, tag2_q, tag2_d, rob_tag_q, rob_tag_d;
  opnd_t                 res1, res2;
  cdb_hit_t              snoop1, snoop2;

  // Widen a 32-bit signed immediate to the datapath width.
  function automatic logic signed [DATA_W-1:0] sext(input logic signed [31:0] v);
    return DATA_W'(v);
  endfunction

  // Lowest-indexed valid CDB port broadcasting the given tag.
  function automatic cdb_hit_t cdb_lookup(input logic [ROB_TAG_W-1:0] tag);
    cdb_hit_t r;
    r.hit = 1'b0;
    r.val = '0;
    for (int i = CDB_PORTS - 1; i >= 0; i--) begin
      if (cdb_valid[i] && (cdb_tag[i*ROB_TAG_W +: ROB_TAG_W] == tag)) begin
        r.hit = 1'b1;
        r.val = cdb_value[i*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  // Operand source priority: x0, regfile, CDB this cycle, ROB, else wait on tag.
  function automatic opnd_t resolve(input logic [4:0] idx, input logic busy,
                                    input logic [ROB_TAG_W-1:0] tag,
                                    input logic [DATA_W-1:0] rf_val, input logic rob_rdy,
                                    input logic [DATA_W-1:0] rob_val);
    opnd_t    r;
    cdb_hit_t h;
    r.val = '0;
    r.tag = '0;
    h = cdb_lookup(tag);
    if (idx != 5'd0) begin
      if (!busy)        r.val = rf_val;
      else if (h.hit)   r.val = h.val;
      else if (rob_rdy) r.val = rob_val;
      else              r.tag = tag;
    end
    return r;
  endfunction

  // Instruction decode: op, immediate, register indices, legality.
  always_comb begin
    dec_op = OP_NOP; dec_imm = '0; dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0;
    dec_illegal = 1'b0;
    case (in_inst[6:0])
      7'b0110111: begin dec_op = OP_LUI;   dec_imm = sext({in_inst[31:12], 12'b0}); dec_rd = in_inst[11:7]; end
      7'b0010111: begin dec_op = OP_AUIPC; dec_imm = sext({in_inst[31:12], 12'b0}); dec_rd = in_inst[11:7]; end
      7'b1101111: begin
        dec_op = OP_JAL; dec_rd = in_inst[11:7];
        dec_imm = sext({{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0});
      end
      7'b1100111: begin
        dec_op = OP_JALR; dec_rd = in_inst[11:7]; dec_rs1 = in_inst[19:15];
        dec_imm = sext({{20{in_inst[31]}}, in_inst[31:20]});
        if (in_inst[14:12] != 3'b000) dec_illegal = 1'b1;
      end
      7'b1100011: begin
        dec_rs1 = in_inst[19:15]; dec_rs2 = in_inst[24:20];
        dec_imm = sext({{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0});
        case (in_inst[14:12])
          3'b000: dec_op = OP_BEQ;   3'b001: dec_op = OP_BNE;
          3'b100: dec_op = OP_BLT;   3'b101: dec_op = OP_BGE;
          3'b110: dec_op = OP_BLTU;  3'b111: dec_op = OP_BGEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec_rd = in_inst[11:7]; dec_rs1 = in_inst[19:15];
        dec_imm = sext({{20{in_inst[31]}}, in_inst[31:20]});
        case (in_inst[14:12])
          3'b000: dec_op = OP_LB;  3'b001: dec_op = OP_LH;  3'b010: dec_op = OP_LW;
          3'b100: dec_op = OP_LBU; 3'b101: dec_op = OP_LHU;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec_rs1 = in_inst[19:15]; dec_rs2 = in_inst[24:20];
        dec_imm = sext({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
        case (in_inst[14:12])
          3'b000: dec_op = OP_SB; 3'b001: dec_op = OP_SH; 3'b010: dec_op = OP_SW;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec_rd = in_inst[11:7]; dec_rs1 = in_inst[19:15];
        dec_imm = sext({{20{in_inst[31]}}, in_inst[31:20]});
        case (in_inst[14:12])
          3'b000: dec_op = OP_ADDI;  3'b010: dec_op = OP_SLTI;
          3'b011: dec_op = OP_SLTIU; 3'b100: dec_op = OP_XORI;
          3'b110: dec_op = OP_ORI;   3'b111: dec_op = OP_ANDI;
          3'b001: dec_op = OP_SLLI;
          default: dec_op = in_inst[30] ? OP_SRAI : OP_SRLI;
        endcase
      end
      7'b0110011: begin
        dec_rd = in_inst[11:7]; dec_rs1 = in_inst[19:15]; dec_rs2 = in_inst[24:20];
        case (in_inst[14:12])
          3'b000: dec_op = in_inst[30] ? OP_SUB : OP_ADD;
          3'b001: dec_op = OP_SLL;  3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU; 3'b100: dec_op = OP_XOR;
          3'b101: dec_op = in_inst[30] ? OP_SRA : OP_SRL;
          3'b110: dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    if (in_inst == 32'd0) dec_illegal = 1'b1;
    if (dec_illegal) begin
      dec_op = OP_NOP; dec_imm = '0; dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0;
    end
  end

  assign rs1        = dec_rs1;
  assign rs2        = dec_rs2;
  assign query_tag1 = in_busy1 ? in_tag1 : '0;
  assign query_tag2 = in_busy2 ? in_tag2 : '0;
  assign accept     = in_valid && in_ready;

  // Handshake outputs derived from the current state.
  always_comb begin
    out_valid = (state_q == S_FULL);
    in_ready  = !rst && !flush && !rob_full && ((state_q == S_EMPTY) || out_ready);
  end

  // Next state: flush empties, accept fills, dispatch without refill empties.
  always_comb begin
    state_d = state_q;
    if (flush)                                 state_d = S_EMPTY;
    else if (accept)                           state_d = S_FULL;
    else if ((state_q == S_FULL) && out_ready) state_d = S_EMPTY;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // Entry payload: capture on accept, otherwise hold while snooping pending tags.
  always_comb begin
    res1   = resolve(dec_rs1, in_busy1, in_tag1, in_operand1, in_tag1_ready, ready_value1);
    res2   = resolve(dec_rs2, in_busy2, in_tag2, in_operand2, in_tag2_ready, ready_value2);
    snoop1 = cdb_lookup(tag1_q);
    snoop2 = cdb_lookup(tag2_q);
    op_d = op_q; imm_d = imm_q; rd_d = rd_q; illegal_d = illegal_q;
    opnd1_d = opnd1_q; opnd2_d = opnd2_q; tag1_d = tag1_q; tag2_d = tag2_q;
    rob_tag_d = rob_tag_q; pc_d = pc_q;
    if ((tag1_q != '0) && snoop1.hit) begin opnd1_d = snoop1.val; tag1_d = '0; end
    if ((tag2_q != '0) && snoop2.hit) begin opnd2_d = snoop2.val; tag2_d = '0; end
    if (accept) begin
      op_d = dec_op; imm_d = dec_imm; rd_d = dec_rd; illegal_d = dec_illegal;
      opnd1_d = res1.val; tag1_d = res1.tag; opnd2_d = res2.val; tag2_d = res2.tag;
      rob_tag_d = rob_alloc_tag; pc_d = in_pc;
    end
  end

  // Entry payload registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0; imm_q <= '0; rd_q <= '0; illegal_q <= 1'b0;
      opnd1_q <= '0; opnd2_q <= '0; tag1_q <= '0; tag2_q <= '0;
      rob_tag_q <= '0; pc_q <= '0;
    end else begin
      op_q <= op_d; imm_q <= imm_d; rd_q <= rd_d; illegal_q <= illegal_d;
      opnd1_q <= opnd1_d; opnd2_q <= opnd2_d; tag1_q <= tag1_d; tag2_q <= tag2_d;
      rob_tag_q <= rob_tag_d; pc_q <= pc_d;
    end
  end

  assign out_op       = op_q;
  assign out_imm      = imm_q;
  assign out_rd       = rd_q;
  assign out_operand1 = opnd1_q;
  assign out_operand2 = opnd2_q;
  assign out_tag1     = tag1_q;
  assign out_tag2     = tag2_q;
  assign out_rob_tag  = rob_tag_q;
  assign out_pc       = pc_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign out_illegal  = illegal_q;
`else
  // Legality still forces illegal encodings to NOP; the flag itself is not exported.
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_decode_dispatch.sv
// tb_decode_dispatch: directed bench for decode_dispatch (decode, operand resolution,
// CDB snoop, flush, reset, back-to-back, ROB-full).
module tb_decode_dispatch;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_inst, in_pc;
  logic [4:0]  rs1, rs2;
  logic        in_busy1, in_busy2;
  logic [3:0]  in_tag1, in_tag2, query_tag1, query_tag2;
  logic [31:0] in_operand1, in_operand2, ready_value1, ready_value2;
  logic        in_tag1_ready, in_tag2_ready, rob_full;
  logic [3:0]  rob_alloc_tag;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        out_valid, out_ready;
  logic [5:0]  out_op;
  logic [31:0] out_imm, out_operand1, out_operand2, out_pc;
  logic [4:0]  out_rd;
  logic [3:0]  out_tag1, out_tag2, out_rob_tag;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [5:0] NOP = 6'd0, LUI = 6'd1, JAL = 6'd3, BEQ = 6'd5, SW = 6'd18,
                         ADDI = 6'd19, ADD = 6'd28, SUB = 6'd29;

  decode_dispatch dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .rs1(rs1), .rs2(rs2),
    .in_busy1(in_busy1), .in_busy2(in_busy2), .in_tag1(in_tag1), .in_tag2(in_tag2),
    .in_operand1(in_operand1), .in_operand2(in_operand2),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .in_tag1_ready(in_tag1_ready), .in_tag2_ready(in_tag2_ready),
    .ready_value1(ready_value1), .ready_value2(ready_value2),
    .rob_full(rob_full), .rob_alloc_tag(rob_alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_imm(out_imm),
    .out_rd(out_rd), .out_operand1(out_operand1), .out_operand2(out_operand2),
    .out_tag1(out_tag1), .out_tag2(out_tag2), .out_rob_tag(out_rob_tag), .out_pc(out_pc)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .out_illegal(out_illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_inst = 32'h0; in_pc = 32'h0;
    in_busy1 = 0; in_busy2 = 0; in_tag1 = 0; in_tag2 = 0;
    in_operand1 = 0; in_operand2 = 0; in_tag1_ready = 0; in_tag2_ready = 0;
    ready_value1 = 0; ready_value2 = 0; rob_full = 0; rob_alloc_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; out_ready = 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    step(); step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
    n_tests++; if (out_op !== 6'd0 || out_imm !== 32'd0 || out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_fields: got op %0h imm %0h rd %0h want 0", out_op, out_imm, out_rd); end
    n_tests++; if (out_operand1 !== 32'd0 || out_tag1 !== 4'd0 || out_pc !== 32'd0 || out_rob_tag !== 4'd0) begin n_fail++; $display("FAIL reset_operands: got %0h %0h %0h %0h want 0", out_operand1, out_tag1, out_pc, out_rob_tag); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 0", in_ready); end
    rst = 0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %0h want 1", in_ready); end
  endtask

  task automatic test_addi();
    idle();
    in_valid = 1; in_inst = 32'hFFD00293; in_pc = 32'h100; rob_alloc_tag = 4'd9;
    in_operand1 = 32'h55;
    #1;
    n_tests++; if (rs1 !== 5'd0 || rs2 !== 5'd0) begin n_fail++; $display("FAIL addi_rs: got %0d %0d want 0 0", rs1, rs2); end
    step();
    in_valid = 0;
    n_tests++; if (out_valid !== 1'b1 || out_op !== ADDI) begin n_fail++; $display("FAIL addi_op: got v%0h op %0d want v1 op %0d", out_valid, out_op, ADDI); end
    n_tests++; if (out_imm !== 32'hFFFFFFFD || out_rd !== 5'd5) begin n_fail++; $display("FAIL addi_imm_rd: got %0h %0d want fffffffd 5", out_imm, out_rd); end
    n_tests++; if (out_tag1 !== 4'd0 || out_operand1 !== 32'd0) begin n_fail++; $display("FAIL addi_src1: got tag %0h val %0h want 0 0", out_tag1, out_operand1); end
    n_tests++; if (out_pc !== 32'h100 || out_rob_tag !== 4'd9) begin n_fail++; $display("FAIL addi_pc_rob: got %0h %0h want 100 9", out_pc, out_rob_tag); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %0h want 0", out_valid); end
  endtask

  task automatic test_snoop_stall();
    idle();
    in_valid = 1; in_inst = 32'h002081B3; out_ready = 0;
    in_busy1 = 1; in_tag1 = 4'd4; in_operand2 = 32'h22;
    #1;
    n_tests++; if (rs1 !== 5'd1 || rs2 !== 5'd2) begin n_fail++; $display("FAIL add_rs: got %0d %0d want 1 2", rs1, rs2); end
    n_tests++; if (query_tag1 !== 4'd4 || query_tag2 !== 4'd0) begin n_fail++; $display("FAIL add_query: got %0h %0h want 4 0", query_tag1, query_tag2); end
    step();
    in_valid = 0; in_busy1 = 0; in_tag1 = 0;
    n_tests++; if (out_op !== ADD || out_rd !== 5'd3) begin n_fail++; $display("FAIL add_op: got %0d rd %0d want %0d rd 3", out_op, out_rd, ADD); end
    n_tests++; if (out_tag1 !== 4'd4 || out_operand1 !== 32'd0 || out_operand2 !== 32'h22) begin n_fail++; $display("FAIL add_capture: got t%0h v%0h v2 %0h want t4 v0 v2 22", out_tag1, out_operand1, out_operand2); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %0h want 0", in_ready); end
    step();
    cdb_valid = 2'b10; cdb_tag = {4'd4, 4'd0}; cdb_value = {32'h1234, 32'h0};
    step();
    cdb_valid = 0;
    n_tests++; if (out_tag1 !== 4'd0 || out_operand1 !== 32'h1234) begin n_fail++; $display("FAIL snoop: got t%0h v%0h want t0 v1234", out_tag1, out_operand1); end
    n_tests++; if (out_valid !== 1'b1 || out_op !== ADD) begin n_fail++; $display("FAIL snoop_hold: got v%0h op %0d want v1 op %0d", out_valid, out_op, ADD); end
    out_ready = 1;
    step();
  endtask

  task automatic test_cdb_priority();
    idle();
    in_valid = 1; in_inst = 32'h002081B3;
    in_busy1 = 1; in_tag1 = 4'd5; in_tag1_ready = 1; ready_value1 = 32'h99;
    in_busy2 = 1; in_tag2 = 4'd7;
    cdb_valid = 2'b11; cdb_tag = {4'd7, 4'd7}; cdb_value = {32'hB, 32'hA};
    step();
    idle();
    n_tests++; if (out_operand2 !== 32'hA || out_tag2 !== 4'd0) begin n_fail++; $display("FAIL cdb_prio: got v%0h t%0h want vA t0", out_operand2, out_tag2); end
    n_tests++; if (out_operand1 !== 32'h99 || out_tag1 !== 4'd0) begin n_fail++; $display("FAIL rob_ready: got v%0h t%0h want v99 t0", out_operand1, out_tag1); end
    step();
  endtask

  task automatic test_flush();
    idle();
    in_valid = 1; in_inst = 32'hFFD00293; out_ready = 0;
    step();
    in_inst = 32'h123453B7; flush = 1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0h want 0", in_ready); end
    step();
    flush = 0; in_valid = 0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0h want 0", out_valid); end
    n_tests++; if (out_rd !== 5'd5) begin n_fail++; $display("FAIL flush_no_capture: got rd %0d want 5", out_rd); end
    out_ready = 1;
  endtask

  task automatic test_illegal();
    idle();
    in_valid = 1; in_inst = 32'h0; in_operand1 = 32'h77;
    #1;
    n_tests++; if (rs1 !== 5'd0 || rs2 !== 5'd0) begin n_fail++; $display("FAIL zero_rs: got %0d %0d want 0 0", rs1, rs2); end
    step();
    in_inst = 32'h0020B023;
    n_tests++; if (out_valid !== 1'b1 || out_op !== NOP || out_rd !== 5'd0 || out_imm !== 32'd0) begin n_fail++; $display("FAIL zero_nop: got v%0h op %0d rd %0d imm %0h want v1 nop rd0 imm0", out_valid, out_op, out_rd, out_imm); end
`ifdef DECODE_ILLEGAL_TRAP_EN
    n_tests++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL zero_illegal: got %0h want 1", out_illegal); end
`endif
    step();
    in_valid = 0;
    n_tests++; if (out_op !== NOP || out_operand1 !== 32'd0) begin n_fail++; $display("FAIL bad_store: got op %0d v%0h want nop v0", out_op, out_operand1); end
`ifdef DECODE_ILLEGAL_TRAP_EN
    n_tests++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL bad_store_illegal: got %0h want 1", out_illegal); end
`endif
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [5];
    logic [5:0]  ops [5];
    logic [31:0] imms [5];
    logic [4:0]  rds [5];
    insts = '{32'h123453B7, 32'h0020A423, 32'hFE208EE3, 32'h40208233, 32'h008000EF};
    ops   = '{LUI, SW, BEQ, SUB, JAL};
    imms  = '{32'h12345000, 32'h8, 32'hFFFFFFFC, 32'h0, 32'h8};
    rds   = '{5'd7, 5'd0, 5'd0, 5'd4, 5'd1};
    idle();
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_inst = insts[i]; in_pc = 32'h200 + 32'(i * 4);
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0h want 1", i, in_ready); end
      step();
      n_tests++; if (out_valid !== 1'b1 || out_op !== ops[i] || out_imm !== imms[i] || out_rd !== rds[i] || out_pc !== 32'h200 + 32'(i * 4)) begin
        n_fail++; $display("FAIL b2b[%0d]: got v%0h op %0d imm %0h rd %0d pc %0h want v1 op %0d imm %0h rd %0d", i, out_valid, out_op, out_imm, out_rd, out_pc, ops[i], imms[i], rds[i]);
      end
    end
    in_valid = 0;
    step();
  endtask

  task automatic test_rob_full();
    idle();
    in_valid = 1; in_inst = 32'hFFD00293; out_ready = 0;
    step();
    in_inst = 32'h123453B7; rob_full = 1; out_ready = 1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL robfull_in_ready: got %0h want 0", in_ready); end
    step();
    n_tests++; if (out_valid !== 1'b0 || out_rd !== 5'd5) begin n_fail++; $display("FAIL robfull_dispatch: got v%0h rd %0d want v0 rd5", out_valid, out_rd); end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    idle();
    in_valid = 1; in_inst = 32'hFFD00293; out_ready = 0;
    step();
    in_valid = 0; rst = 1;
    step();
    rst = 0;
    n_tests++; if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_op !== 6'd0) begin n_fail++; $display("FAIL reset_stall: got v%0h rd %0d op %0d want 0 0 0", out_valid, out_rd, out_op); end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_addi();
    test_snoop_stall();
    test_cdb_priority();
    test_flush();
    test_illegal();
    test_back_to_back();
    test_rob_full();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/decode_dispatch.md
Name: decode_dispatch

Overview:
- Parametrised decode-and-dispatch stage for the out-of-order RV32I core. Sits between the fetch queue and the reservation stations / load-store buffer.
- Decodes one instruction per cycle into operation code, immediate and register indices. Resolves source operands from the regfile, the ROB and the CDB, then holds the result in a one-entry output register with valid/ready handshakes on both sides.
- While a decoded instruction is stalled in the output register, the block snoops the CDB so that stale tags are resolved before dispatch.

Parameters:
- DATA_W, 32, operand/PC/immediate width
- ROB_TAG_W, 4, ROB tag width; tag 0 means "no dependency, value valid"
- CDB_PORTS, 2, number of CDB broadcast ports snooped
- OP_W, 6, width of the operation code from the team operation-code header

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  misprediction flush; kills the held and the incoming instruction
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  DATA_W  instruction PC
- rs1, rs2  out  5 each  combinational regfile indices from in_inst; 0 for an unused source
- in_busy1/2  in  1 each  regfile entry awaits a ROB result
- in_tag1/2  in  ROB_TAG_W each  regfile rename tag
- in_operand1/2  in  DATA_W each  regfile value
- query_tag1/2  out  ROB_TAG_W each  busy ? in_tag : 0
- in_tag1_ready/2  in  1 each  ROB entry already holds its result
- ready_value1/2  in  DATA_W each  ROB value
- rob_full  in  1  ROB cannot allocate
- rob_alloc_tag  in  ROB_TAG_W  tag the ROB assigns to this instruction
- cdb_valid  in  CDB_PORTS  per-port broadcast valid
- cdb_tag  in  CDB_PORTS*ROB_TAG_W  flattened; port i at [i*ROB_TAG_W +: ROB_TAG_W]
- cdb_value  in  CDB_PORTS*DATA_W  flattened likewise
- out_valid  out  1  dispatch entry valid
- out_ready  in  1  downstream RS accepts
- out_op  out  OP_W  operation code
- out_imm  out  DATA_W  sign/zero-formed immediate (I/S/B/U/J)
- out_rd  out  5  destination register; 0 for branch and store
- out_operand1/2  out  DATA_W each  source value, valid when the matching tag is 0
- out_tag1/2  out  ROB_TAG_W each  pending producer tag or 0
- out_rob_tag  out  ROB_TAG_W  captured rob_alloc_tag
- out_pc  out  DATA_W  captured in_pc

Behaviour:
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !rst && !flush && !rob_full && (!out_valid || out_ready). Acceptance = in_valid && in_ready.
- Latency: an accepted instruction appears on out_* in the next cycle. Back-to-back acceptance gives 1 instruction per cycle.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + out_ready + accept -> FULL with the new entry.
  - FULL + out_ready + no accept -> EMPTY.
  - FULL + !out_ready -> hold all fields except snooped operands.
- Operand resolution at capture, in priority order:
  1. Register index 0: value 0, tag 0.
  2. Regfile not busy: in_operand, tag 0.
  3. A CDB port this cycle with cdb_valid and a tag matching in_tag: that cdb_value, tag 0; lowest port index wins.
  4. in_tag_ready: ready_value, tag 0.
  5. Otherwise: operand 0, tag = in_tag.
- Snoop in FULL: for each out_tagN != 0 matching any valid CDB port, replace out_operandN with the value and set out_tagN to 0 next cycle. This also applies in the cycle the entry dispatches.
- Decode coverage:
  - LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP, OP-IMM.
  - OP and OP-IMM: funct7 bit 30 selects SUB/SRA/SRAI; otherwise ADD/SRL/SRLI.
  - STORE funct3 000/001/010 maps to SB/SH/SW.
  - Unused sources report index 0.
  - Unknown opcode or funct3: NOP, imm 0, rd 0, both sources 0.
- Flush has priority over accept. Next cycle: out_valid=0, state EMPTY; in_ready=0 during the flush cycle.
- Reset: out_valid=0 and every out_* register = 0. Reset in the middle of a stall discards the held entry.
- rob_full while FULL and out_ready: the held entry still dispatches; nothing new is accepted.

Optional Feature:
- DECODE_ILLEGAL_TRAP_EN
  - Defined: adds output out_illegal (1 bit), registered alongside the entry. It is 1 for an unknown opcode or funct3, or for an all-zero instruction word; the entry still dispatches as NOP with rd 0 so the ROB can raise the trap.
  - Undefined: the port is absent and illegal encodings silently become NOP.

Test Plan:
- rst held 2 cycles -> out_valid=0, all out_* 0, in_ready=0; after release with rob_full=0, in_ready=1.
- addi x5,x0,-3 (0xFFD00293), out_ready=1 -> next cycle out_op=ADDI, out_imm=0xFFFFFFFD, out_rd=5, out_tag1=0, out_operand1=0.
- add x3,x1,x2 with x1 busy tag 4, ROB not ready; out_ready=0; two cycles later cdb port1 tag 4 value 0x1234 -> out_tag1=0, out_operand1=0x1234 next cycle; entry still held.
- Capture with x2 busy tag 7 while cdb port0 and port1 both broadcast tag 7 (values 0xA, 0xB) -> out_operand2=0xA, out_tag2=0.
- FULL, out_ready=0, flush=1 with in_valid=1 -> next cycle out_valid=0, no new entry captured.
- Instruction 0x00000000 -> out_op=NOP, out_rd=0; with DECODE_ILLEGAL_TRAP_EN, out_illegal=1.
